// File: rtl/reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// reset_sequencer_if
//   Groups the board-level reset manager signals so the sequencer and the
//   board top can be connected with a single port.
//
//   Signals:
//     btn              raw reset push-button, active high, asynchronous
//     pll_lock         PLL LOCKED, asynchronous
//     init_done        memory calibration complete, asynchronous
//     rst_out          per-domain synchronous resets, active high
//     busy             high while the sequencer is not in RUN
//     seq_state        ASSERT=0, RELEASE=1, WAIT_INIT=2, RUN=3
//     lock_lost_count  saturating count of PLL lock falling edges
//
//   Modports:
//     master  the reset sequencer (consumes raw inputs, drives resets)
//     slave   the board side (drives raw inputs, consumes resets)
// ---------------------------------------------------------------------------
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   btn;
  logic                   pll_lock;
  logic                   init_done;
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   busy;
  logic [1:0]             seq_state;
  logic [7:0]             lock_lost_count;

  modport master (
    input  btn, pll_lock, init_done,
    output rst_out, busy, seq_state, lock_lost_count
  );

  modport slave (
    output btn, pll_lock, init_done,
    input  rst_out, busy, seq_state, lock_lost_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Board-level reset manager. Synchronises the reset button, PLL lock and
//   memory init_done, debounces the button, holds every reset domain until
//   lock has been stable, then releases the domains one at a time. The last
//   domain (CPU) waits for init_done. A debounced button press or a falling
//   edge of lock restarts the whole sequence.
//
//   Ports:
//     clk    single clock (cpu_clk_g domain)
//     rst_n  asynchronous active-low reset
//     sq     reset_sequencer_if.master (btn, pll_lock, init_done in;
//            rst_out, busy, seq_state, lock_lost_count out)
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_DOMAINS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HOLD_CYCLES     = 4,
  parameter int STRETCH         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  reset_sequencer_if.master   sq
);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_WAIT_INIT = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int CNT_MAX = (HOLD_CYCLES > STRETCH) ? HOLD_CYCLES : STRETCH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W   = $clog2(NUM_DOMAINS);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [DB_W-1:0]  DB_MAX       = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_PRE       = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 2);

  // Saturating event counter (sticks at 255).
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Debounce counter: clears on a low sample, saturates at DEBOUNCE_CYCLES.
  function automatic logic [DB_W-1:0] db_next(input logic s, input logic [DB_W-1:0] c);
    if (!s)          return '0;
    if (c == DB_MAX) return c;
    return c + DB_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] btn_sync_p0, lock_sync_p0, init_sync_p0;
  logic                   btn_s, lock_s, init_s;
  logic                   lock_d_p1;
  logic [DB_W-1:0]        db_cnt_p1;
  logic                   press_p1;
  logic [7:0]             lock_lost_cnt;
  logic                   lock_fall, restart;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [IDX_W-1:0]       idx, idx_nx;
  logic [NUM_DOMAINS-1:0] rst_out_r, rst_out_nx;

  assign btn_s  = btn_sync_p0[SYNC_STAGES-1];
  assign lock_s = lock_sync_p0[SYNC_STAGES-1];
  assign init_s = init_sync_p0[SYNC_STAGES-1];

  // Stage p0: synchronisers; stage p1: edge detect, debounce, press pulse.
  // press is registered so it fires exactly once, on the cycle db_cnt
  // first reads DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_p0   <= '0;
      lock_sync_p0  <= '0;
      init_sync_p0  <= '0;
      lock_d_p1     <= 1'b0;
      db_cnt_p1     <= '0;
      press_p1      <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      btn_sync_p0   <= {btn_sync_p0[SYNC_STAGES-2:0], sq.btn};
      lock_sync_p0  <= {lock_sync_p0[SYNC_STAGES-2:0], sq.pll_lock};
      init_sync_p0  <= {init_sync_p0[SYNC_STAGES-2:0], sq.init_done};
      lock_d_p1     <= lock_s;
      db_cnt_p1     <= db_next(btn_s, db_cnt_p1);
      press_p1      <= btn_s && (db_cnt_p1 == DB_PRE);
      if (lock_fall) lock_lost_cnt <= sat_inc8(lock_lost_cnt);
    end
  end

  assign lock_fall = lock_d_p1 & ~lock_s;
  // A simultaneous press and lock drop is a single restart.
  assign restart   = press_p1 | lock_fall;

  // Sequencer state register; rst_out resets to all ones so an async reset
  // mid-sequence can only set bits, never glitch them low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      idx       <= '0;
      rst_out_r <= '1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      rst_out_r <= rst_out_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    rst_out_nx = rst_out_r;
    if (restart) begin
      state_nx   = ST_ASSERT;
      cnt_nx     = '0;
      idx_nx     = '0;
      rst_out_nx = '1;
    end else begin
      case (state)
        ST_ASSERT: begin
          rst_out_nx = '1;
          if (!lock_s) begin
            cnt_nx = '0;
          end else if (cnt == HOLD_LAST) begin
            state_nx = ST_RELEASE;
            cnt_nx   = '0;
            idx_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == STRETCH_LAST) begin
            rst_out_nx[idx] = 1'b0;
            cnt_nx          = '0;
            idx_nx          = idx + IDX_W'(1);
            // The CPU domain is left for WAIT_INIT.
            if (idx == IDX_LAST) state_nx = ST_WAIT_INIT;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        ST_WAIT_INIT: begin
          if (init_s) begin
            rst_out_nx[NUM_DOMAINS-1] = 1'b0;
            state_nx                  = ST_RUN;
          end
        end
        ST_RUN: begin
          rst_out_nx = '0;
        end
        default: begin
          state_nx   = ST_ASSERT;
          cnt_nx     = '0;
          idx_nx     = '0;
          rst_out_nx = '1;
        end
      endcase
    end
  end

  assign sq.rst_out         = rst_out_r;
  assign sq.busy            = (state != ST_RUN);
  assign sq.seq_state       = state;
  assign sq.lock_lost_count = lock_lost_cnt;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised reset manager replacing the fixed button-delay/stretch logic at the board top level.
- Synchronises and debounces the reset button and the PLL lock signal.
- Holds all reset domains asserted until lock is stable, then releases NUM_DOMAINS resets one at a time.
- The last domain (CPU) is released only after memory init_done; lock loss or a button press restarts the sequence.

Parameters:
- NUM_DOMAINS, 3, number of reset outputs; legal range >= 2. Bit 0 is released first; bit NUM_DOMAINS-1 is the CPU domain.
- SYNC_STAGES, 2, flop depth of the synchronisers for btn, pll_lock and init_done; legal range >= 2.
- DEBOUNCE_CYCLES, 8, consecutive synchronised-high cycles of btn needed to register a press; legal range >= 1.
- HOLD_CYCLES, 4, cycles with lock high before the release sequence starts; legal range >= 1.
- STRETCH, 4, cycles between successive domain releases; legal range >= 1.

Ports:
- clk, in, 1, single clock (cpu_clk_g domain).
- rst_n, in, 1, asynchronous active-low reset.
- btn, in, 1, raw reset push-button, active high, asynchronous.
- pll_lock, in, 1, PLL LOCKED, asynchronous.
- init_done, in, 1, memory calibration complete, asynchronous.
- rst_out, out, NUM_DOMAINS, per-domain synchronous reset, active high.
- busy, out, 1, high whenever state != RUN.
- seq_state, out, 2, current state: ASSERT=0, RELEASE=1, WAIT_INIT=2, RUN=3.
- lock_lost_count, out, 8, saturating count of lock falling edges.

Behaviour:
- Async reset (rst_n=0) values:
  - state=ASSERT; rst_out=all 1s; busy=1; lock_lost_count=0.
  - All synchroniser flops=0; debounce counter=0; internal cnt=0; idx=0.
- All outputs are registered, with no combinational path from any input to any output.
- Synchronisers: btn_s, lock_s and init_s are each SYNC_STAGES flops deep. lock_d is lock_s delayed by one cycle.
- Debounce:
  - btn_s=0 clears db_cnt.
  - btn_s=1 increments db_cnt, saturating at DEBOUNCE_CYCLES.
  - press is a 1-cycle internal pulse on the cycle db_cnt transitions to DEBOUNCE_CYCLES, so exactly one press per hold.
- lock_fall = lock_d & ~lock_s. On lock_fall, lock_lost_count increments, saturating at 255.
- Restart event = press | lock_fall. It has highest priority in every state, including ASSERT:
  - next state=ASSERT, cnt=0, idx=0.
  - rst_out=all 1s on the next edge.
- ASSERT:
  - lock_s=0: cnt=0.
  - lock_s=1: cnt increments. When cnt==HOLD_CYCLES-1, go to RELEASE with cnt=0, idx=0.
- RELEASE:
  - cnt increments. When cnt==STRETCH-1: clear rst_out[idx], idx++, cnt=0.
  - After clearing index NUM_DOMAINS-2, go to WAIT_INIT.
  - Domain k (k < NUM_DOMAINS-1) deasserts STRETCH*(k+1) cycles after RELEASE entry.
- WAIT_INIT:
  - init_s=0: hold.
  - init_s=1: clear rst_out[NUM_DOMAINS-1] and go to RUN on the same edge.
- RUN:
  - All rst_out=0, busy=0.
  - Stays in RUN until a restart event.
- Deassertion of rst_out bits is monotonic: bits only clear in index order and all bits set together.
- lock_s low while in RELEASE or WAIT_INIT without a falling edge cannot occur (entry requires lock_s=1, and any drop produces lock_fall).
- rst_n asserted mid-sequence: immediate return to reset values, with no glitch to 0 on rst_out.
- Simultaneous press and lock_fall: a single restart; the counter increments once.

Test Plan:
- Power-up: rst_n released with pll_lock=1, init_done=1, defaults -> rst_out stays 3'b111 for 2 (sync) + 4 (hold) cycles. Then bit0 clears 4 cycles after RELEASE entry and bit1 clears 4 cycles later. Bit2 clears when WAIT_INIT sees init_s=1. busy=0, seq_state=3.
- Lock gating: pll_lock=0 for 50 cycles after reset -> rst_out=3'b111 and seq_state=0 throughout. Release proceeds HOLD_CYCLES cycles after lock_s rises.
- Init gating: init_done=0 -> sequence stops at rst_out=3'b100, seq_state=2. Raising init_done clears bit2 SYNC_STAGES+1 cycles later.
- Debounce:
  - btn high for 7 cycles, then low -> no restart.
  - btn high for 20 cycles in RUN -> exactly one restart: rst_out=3'b111 on the cycle after db_cnt reaches 8, and the full sequence reruns.
- Lock loss:
  - pll_lock drop in RUN -> rst_out=3'b111 and lock_lost_count=1.
  - 300 drop pulses -> lock_lost_count saturates at 255.
- Mid-sequence:
  - btn press during RELEASE (after bit0 cleared) -> all bits set again, cnt/idx restart.
  - rst_n pulse during WAIT_INIT -> all reset values, counter cleared.
